// File: rtl/sequenciador_preparo_if.sv
// Bus between the main control FSM / display logic and the drink preparation
// sequencer. Clock and reset are plain module ports.
//
// Protocol: there is no valid/ready handshake. start, cancel and tick_1hz are
// single-cycle pulses that are taken on the rising clock edge where they are
// high. bebida is sampled only on an accepted start, and erro_sensor is a level.
// All slave outputs are registered.
interface sequenciador_preparo_if;
  logic       tick_1hz;
  logic       start;
  logic [1:0] bebida;
  logic       erro_sensor;
  logic       cancel;
  logic [2:0] estado;
  logic [3:0] seg_rest;
  logic       ocupado;
  logic       concluido;
  logic       aquecedor;
  logic       valvula;
  logic       rgb_red;
  logic       rgb_green;
  logic       rgb_blue;

  modport master (
    output tick_1hz, start, bebida, erro_sensor, cancel,
    input  estado, seg_rest, ocupado, concluido, aquecedor, valvula,
           rgb_red, rgb_green, rgb_blue
  );

  modport slave (
    input  tick_1hz, start, bebida, erro_sensor, cancel,
    output estado, seg_rest, ocupado, concluido, aquecedor, valvula,
           rgb_red, rgb_green, rgb_blue
  );
endinterface

// File: rtl/sequenciador_preparo.sv
// Drink preparation sequencer: heating -> pressurization -> delivery, each
// phase timed in 1 Hz ticks by one shared down-counter, with a timed error
// phase on sensor fault. estado exposes the FSM state directly.
module sequenciador_preparo #(
  parameter int unsigned T_AQUECI  = 10,
  parameter int unsigned T_PRESSU  = 2,
  parameter int unsigned T_ENTREGA = 2,
  parameter int unsigned T_ERRO    = 6
) (
  input logic                   clock,
  input logic                   reset_n,
  sequenciador_preparo_if.slave bus
);

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    AQUECENDO     = 3'd1,
    PRESSURIZANDO = 3'd2,
    ENTREGANDO    = 3'd3,
    CONCLUIDO     = 3'd4,
    ERRO          = 3'd5
  } estado_t;

  localparam logic [3:0] LEN_AQUECI  = 4'(T_AQUECI);
  localparam logic [3:0] LEN_PRESSU  = 4'(T_PRESSU);
  localparam logic [3:0] LEN_ENTREGA = 4'(T_ENTREGA);
  localparam logic [3:0] LEN_ERRO    = 4'(T_ERRO);

  estado_t    state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] bebida_q, bebida_d;

  logic ocupado_q, ocupado_d;
  logic concluido_q, concluido_d;
  logic aquecedor_q, aquecedor_d;
  logic valvula_q, valvula_d;
  logic red_q, red_d;
  logic green_q, green_d;
  logic blue_q, blue_d;

  // Delivery length depends on the drink latched when the run started.
  logic [3:0] len_entrega;
  assign len_entrega = LEN_ENTREGA + {2'b00, bebida_q};

  // State, counter, drink latch and decoded outputs; reset forces idle/green.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= OCIOSO;
      cnt_q       <= 4'd0;
      bebida_q    <= 2'd0;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
      aquecedor_q <= 1'b0;
      valvula_q   <= 1'b0;
      red_q       <= 1'b0;
      green_q     <= 1'b1;
      blue_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bebida_q    <= bebida_d;
      ocupado_q   <= ocupado_d;
      concluido_q <= concluido_d;
      aquecedor_q <= aquecedor_d;
      valvula_q   <= valvula_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
    end
  end

  // Next state: fault beats cancel beats tick; a tick with cnt==1 ends the phase.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bebida_d = bebida_q;
    unique case (state_q)
      OCIOSO: begin
        // A tick arriving with the start is not counted: the load wins.
        if (bus.start && (bus.bebida != 2'd0) && !bus.erro_sensor) begin
          state_d  = AQUECENDO;
          cnt_d    = LEN_AQUECI;
          bebida_d = bus.bebida;
        end
      end
      AQUECENDO, PRESSURIZANDO, ENTREGANDO: begin
        if (bus.erro_sensor) begin
          state_d = ERRO;
          cnt_d   = LEN_ERRO;
        end else if (bus.cancel && (state_q == AQUECENDO)) begin
          // Once pressurization starts water is committed, so cancel is ignored.
          state_d = OCIOSO;
          cnt_d   = 4'd0;
        end else if (bus.tick_1hz) begin
          if (cnt_q == 4'd1) begin
            unique case (state_q)
              AQUECENDO: begin
                state_d = PRESSURIZANDO;
                cnt_d   = LEN_PRESSU;
              end
              PRESSURIZANDO: begin
                state_d = ENTREGANDO;
                cnt_d   = len_entrega;
              end
              default: begin
                state_d = CONCLUIDO;
                cnt_d   = 4'd0;
              end
            endcase
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      CONCLUIDO: begin
        state_d = OCIOSO;
        cnt_d   = 4'd0;
      end
      ERRO: begin
        // Error display runs its full length whatever erro_sensor does.
        if (bus.tick_1hz) begin
          if (cnt_q == 4'd1) begin
            state_d = OCIOSO;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = OCIOSO;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with estado.
  always_comb begin
    ocupado_d   = 1'b0;
    concluido_d = 1'b0;
    aquecedor_d = 1'b0;
    valvula_d   = 1'b0;
    red_d       = 1'b0;
    green_d     = 1'b0;
    blue_d      = 1'b0;
    unique case (state_d)
      OCIOSO: begin
        green_d = 1'b1;
      end
      AQUECENDO: begin
        ocupado_d   = 1'b1;
        aquecedor_d = 1'b1;
        blue_d      = 1'b1;
      end
      PRESSURIZANDO, ENTREGANDO: begin
        ocupado_d = 1'b1;
        valvula_d = 1'b1;
        blue_d    = 1'b1;
      end
      CONCLUIDO: begin
        concluido_d = 1'b1;
        green_d     = 1'b1;
        blue_d      = 1'b1;
      end
      ERRO: begin
        ocupado_d = 1'b1;
        red_d     = 1'b1;
      end
      default: begin
        green_d = 1'b1;
      end
    endcase
  end

  assign bus.estado    = state_q;
  assign bus.seg_rest  = cnt_q;
  assign bus.ocupado   = ocupado_q;
  assign bus.concluido = concluido_q;
  assign bus.aquecedor = aquecedor_q;
  assign bus.valvula   = valvula_q;
  assign bus.rgb_red   = red_q;
  assign bus.rgb_green = green_q;
  assign bus.rgb_blue  = blue_q;

endmodule
